// File: rtl/divider_result_stage.sv
// Result stage for the divider pipeline: forms the signed quotient, flags divide-by-zero
// and buffers results in a first-word-fall-through FIFO with occupancy back-pressure hints.
module divider_result_stage #(
   parameter int QW        = 12,
   parameter int DEPTH     = 4,
   parameter int AF_MARGIN = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [35:0]                remainder_in,
   input  logic [22:0]                divisor_in,
   input  logic                       signbit_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [QW:0]                out_quotient,
   output logic                       out_div_zero,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       almost_full,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = QW + 2;

   // Saturates to the largest magnitude on divide-by-zero; negating zero yields zero.
   function automatic logic [QW:0] form_quotient(input logic [QW-1:0] mag,
                                                 input logic          zero_div,
                                                 input logic          neg);
      logic [QW:0] q;
      if (zero_div) begin
         q = {1'b0, {QW{1'b1}}};
      end else begin
         q = {1'b0, mag};
      end
      return neg ? (~q + {{QW{1'b0}}, 1'b1}) : q;
   endfunction

   logic [EW-1:0] r_mem [DEPTH];
   logic [EW-1:0] r_head;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic          r_out_valid;
   logic          r_almost_full;
   logic          r_overflow;

   logic          w_div_zero;
   logic [QW:0]   w_result;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_reject;
   logic [LW-1:0] w_level_nxt;
   logic [LW-1:0] w_free;
   logic [AW-1:0] w_rd_ptr_inc;
   logic [EW-1:0] w_head_nxt;
   logic          w_unused;

   assign w_unused     = ^remainder_in[35:QW];
   assign w_div_zero   = (divisor_in == 23'd0);
   assign w_result     = form_quotient(remainder_in[QW-1:0], w_div_zero, signbit_in);
   assign w_full       = (r_level == LW'(DEPTH));
   assign w_pop        = r_out_valid & out_ready;
   assign w_push       = in_valid & (~w_full | w_pop);
   assign w_reject     = in_valid & w_full & ~w_pop;
   assign w_rd_ptr_inc = r_rd_ptr + AW'(1);
   assign w_free       = LW'(DEPTH) - w_level_nxt;

   // Occupancy after this edge.
   always_comb begin
      w_level_nxt = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_nxt = r_level + LW'(1);
         2'b01:   w_level_nxt = r_level - LW'(1);
         default: w_level_nxt = r_level;
      endcase
   end

   // Head register only moves on a pop or on a push into an empty FIFO.
   always_comb begin
      w_head_nxt = r_head;
      if (w_push && (r_level == LW'(0))) begin
         w_head_nxt = {w_result, w_div_zero};
      end else if (w_pop && (r_level > LW'(1))) begin
         w_head_nxt = r_mem[w_rd_ptr_inc];
      end else if (w_pop && w_push) begin
         w_head_nxt = {w_result, w_div_zero};
      end else begin
         w_head_nxt = r_head;
      end
   end

   // Storage array; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (w_push && !rst) begin
         r_mem[r_wr_ptr] <= {w_result, w_div_zero};
      end
   end

   // Pointers, occupancy, flags and the registered head.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_level       <= '0;
         r_out_valid   <= 1'b0;
         r_almost_full <= 1'b0;
         r_overflow    <= 1'b0;
         r_head        <= '0;
      end else begin
         r_level       <= w_level_nxt;
         r_out_valid   <= (w_level_nxt != LW'(0));
         r_almost_full <= (w_free <= LW'(AF_MARGIN));
         r_head        <= w_head_nxt;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_ptr_inc;
         end
         if (w_reject) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign out_valid    = r_out_valid;
   assign out_quotient = r_head[EW-1:1];
   assign out_div_zero = r_head[0];
   assign fifo_level   = r_level;
   assign almost_full  = r_almost_full;
   assign overflow     = r_overflow;

endmodule

// File: tb/tb_divider_result_stage.sv
// Directed bench for divider_result_stage: quotient formation, FIFO ordering,
// overflow, simultaneous push/pop and mid-stream reset.
module tb_divider_result_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [35:0] remainder_in;
   logic [22:0] divisor_in;
   logic        signbit_in;
   logic        out_valid;
   logic        out_ready;
   logic [12:0] out_quotient;
   logic        out_div_zero;
   logic [2:0]  fifo_level;
   logic        almost_full;
   logic        overflow;

   int n_tests = 0;
   int n_fail  = 0;

   divider_result_stage #(.QW(12), .DEPTH(4), .AF_MARGIN(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .remainder_in (remainder_in),
      .divisor_in   (divisor_in),
      .signbit_in   (signbit_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_quotient (out_quotient),
      .out_div_zero (out_div_zero),
      .fifo_level   (fifo_level),
      .almost_full  (almost_full),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [35:0] r, input logic [22:0] d, input logic s);
      in_valid     = 1'b1;
      remainder_in = r;
      divisor_in   = d;
      signbit_in   = s;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   // One word through an otherwise empty FIFO with the consumer ready.
   task automatic single(input string tag, input logic [35:0] r, input logic [22:0] d,
                         input logic s, input logic [12:0] exp_q, input logic exp_dz);
      out_ready = 1'b1;
      drive(r, d, s);
      tick();
      idle();
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_q"}, 32'(out_quotient), 32'(exp_q));
      check({tag, "_dz"}, 32'(out_div_zero), 32'(exp_dz));
      tick();
      check({tag, "_drained"}, 32'(out_valid), 32'd0);
      check({tag, "_level0"}, 32'(fifo_level), 32'd0);
   endtask

   logic [12:0] exp_order [4];

   initial begin
      rst          = 1'b1;
      in_valid     = 1'b0;
      remainder_in = 36'd0;
      divisor_in   = 23'd0;
      signbit_in   = 1'b0;
      out_ready    = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_q", 32'(out_quotient), 32'd0);
      check("rst_dz", 32'(out_div_zero), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_af", 32'(almost_full), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);

      single("pos5", 36'h000000005, 23'd3, 1'b0, 13'h0005, 1'b0);
      single("neg5", 36'h000000005, 23'd3, 1'b1, 13'h1FFB, 1'b0);
      single("negzero", 36'hABC000000, 23'd7, 1'b1, 13'h0000, 1'b0);
      single("dz_neg", 36'h123456789, 23'd0, 1'b1, 13'h1001, 1'b1);
      single("dz_pos", 36'h000000ABC, 23'd0, 1'b0, 13'h0FFF, 1'b1);
      single("big_neg", 36'hF00000FFF, 23'd1, 1'b1, 13'h1001, 1'b0);

      // Fill with the consumer stalled, then overflow.
      out_ready = 1'b0;
      drive(36'd1, 23'd1, 1'b0);
      tick();
      check("fill1_level", 32'(fifo_level), 32'd1);
      check("fill1_af", 32'(almost_full), 32'd0);
      check("fill1_head", 32'(out_quotient), 32'd1);
      drive(36'd2, 23'd1, 1'b0);
      tick();
      check("fill2_level", 32'(fifo_level), 32'd2);
      check("fill2_af", 32'(almost_full), 32'd1);
      drive(36'd3, 23'd1, 1'b0);
      tick();
      drive(36'd4, 23'd1, 1'b0);
      tick();
      check("fill4_level", 32'(fifo_level), 32'd4);
      check("fill4_ovf", 32'(overflow), 32'd0);
      check("fill4_head", 32'(out_quotient), 32'd1);
      drive(36'd5, 23'd1, 1'b0);
      tick();
      idle();
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_level", 32'(fifo_level), 32'd4);
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check("drain_valid", 32'(out_valid), 32'd1);
         check("drain_q", 32'(out_quotient), 32'(i));
         tick();
      end
      check("drain_empty", 32'(out_valid), 32'd0);
      check("drain_level", 32'(fifo_level), 32'd0);
      check("ovf_sticky", 32'(overflow), 32'd1);
      check("drain_af", 32'(almost_full), 32'd0);

      // Clear overflow, refill, then push and pop on the same edge while full.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst2_ovf", 32'(overflow), 32'd0);
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive(36'(i), 23'd2, 1'b0);
         tick();
      end
      check("full_level", 32'(fifo_level), 32'd4);
      out_ready = 1'b1;
      drive(36'd9, 23'd2, 1'b0);
      tick();
      idle();
      check("pp_level", 32'(fifo_level), 32'd4);
      check("pp_ovf", 32'(overflow), 32'd0);
      exp_order[0] = 13'd2;
      exp_order[1] = 13'd3;
      exp_order[2] = 13'd4;
      exp_order[3] = 13'd9;
      for (int i = 0; i < 4; i++) begin
         check("pp_valid", 32'(out_valid), 32'd1);
         check("pp_q", 32'(out_quotient), 32'(exp_order[i]));
         tick();
      end
      check("pp_empty", 32'(out_valid), 32'd0);

      // Reset while three entries are stored and a push is offered.
      out_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         drive(36'(i + 20), 23'd5, 1'b0);
         tick();
      end
      check("pre_rst_level", 32'(fifo_level), 32'd3);
      drive(36'd8, 23'd5, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      check("mid_rst_level", 32'(fifo_level), 32'd0);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_ovf", 32'(overflow), 32'd0);
      single("post_rst7", 36'd7, 23'd1, 1'b0, 13'h0007, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/divider_result_stage.md
Name: divider_result_stage

Overview:
- Consumes the last divider_unit pipeline stage (remainder/divisor/sign bundle plus an accompanying valid bit).
- Extracts the quotient bits, applies the sign in two's complement and handles divide-by-zero.
- Buffers results in a small first-word-fall-through FIFO with a valid/ready handshake towards the rasterizer/interpolation consumer.
- The divider pipeline cannot stall, so this block exports occupancy and almost-full back to the issuing logic.

Parameters:
- QW, 12: quotient magnitude width, taken from remainder_in[QW-1:0].
- DEPTH, 4: FIFO entries; power of two, at least 2.
- AF_MARGIN, 2: almost_full asserts when free entries <= AF_MARGIN. Must be at least the number of divider stages in flight after the issue decision.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  pipeline output word valid this cycle
- remainder_in  in  36  final remainder/quotient word from the last divider_unit
- divisor_in  in  23  divisor carried through the pipeline
- signbit_in  in  1  result sign carried through the pipeline
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_quotient  out  QW+1  signed quotient at FIFO head
- out_div_zero  out  1  head entry was a divide-by-zero
- fifo_level  out  $clog2(DEPTH)+1  current occupancy
- almost_full  out  1  free entries <= AF_MARGIN
- overflow  out  1  sticky; a push was dropped

Behaviour:
- Reset: synchronous on rst=1 at a clk edge. Sets out_valid=0, out_quotient=0, out_div_zero=0, fifo_level=0, almost_full=0, overflow=0, and clears read/write pointers.
  - Reset mid-operation discards all stored entries; nothing is popped on that edge.
  - in_valid is ignored while rst=1.
- Result formation (combinational, at input):
  - q = zero-extended remainder_in[QW-1:0] to QW+1 bits.
  - divisor_in==0: result = signbit_in ? -(2^QW-1) : (2^QW-1), div_zero=1.
  - Else signbit_in=1 and q!=0: result = -q (two's complement, QW+1 bits).
  - Else: result = q (no negative zero), div_zero=0.
- Push: on a clk edge with in_valid=1, accepted if the FIFO is not full, or if it is full and a pop occurs on the same edge. The entry {result, div_zero} is written at the write pointer.
- Push rejected (full, no simultaneous pop): entry dropped, overflow set to 1 and held until rst. FIFO contents and level are unchanged.
- Pop: on a clk edge with out_valid=1 and out_ready=1, the head is removed. out_quotient/out_div_zero change only on a pop or a push-into-empty.
- FWFT latency: a word pushed into an empty FIFO appears on out_valid/out_quotient the cycle after the push edge. There is no same-cycle bypass.
- Simultaneous push and pop:
  - Non-empty FIFO: level unchanged, both pointers advance.
  - Empty FIFO: pop is impossible (out_valid=0), so only the push occurs.
- Pointers wrap modulo DEPTH. Full is fifo_level==DEPTH; empty is fifo_level==0.
- fifo_level, almost_full and out_valid are registered and reflect state after the current edge.
  - almost_full = (DEPTH - fifo_level) <= AF_MARGIN.
  - out_valid = fifo_level != 0.
- Holding out_ready=0 keeps the head stable. out_quotient is don't-care while out_valid=0 but must not be X after reset.

Test Plan:
- Basic positive: in_valid=1 for 1 cycle, remainder_in[11:0]=12'h005, divisor_in=3, signbit_in=0, out_ready=1 -> next cycle out_valid=1, out_quotient=13'h0005, out_div_zero=0; one cycle later out_valid=0, fifo_level=0.
- Sign handling:
  - Same word with signbit_in=1 -> out_quotient=13'h1FFB.
  - q=0 with signbit_in=1 -> 13'h0000.
- Divide-by-zero: divisor_in=0, signbit_in=1, any remainder -> out_quotient=13'h1001, out_div_zero=1; signbit_in=0 -> 13'h0FFF.
- Fill/overflow: out_ready=0, push values 1,2,3,4 on consecutive cycles.
  - almost_full=1 once fifo_level=2; fifo_level=4.
  - 5th push (value 5) -> overflow=1, level stays 4.
  - Then out_ready=1 -> outputs 1,2,3,4 in order, 5 never appears, overflow remains 1.
- Full with simultaneous push+pop: FIFO full with 1..4, out_ready=1 and push 9 on the same edge -> no overflow, level stays 4, drain order 2,3,4,9.
- Reset mid-stream: 3 entries stored, assert rst for 1 cycle while pushing -> after the edge fifo_level=0, out_valid=0, overflow=0. The next push of 7 is output as 13'h0007 one cycle later.
